rx_frame_parser: RTL

Sits on the master rx side of the USB data gateway, consuming 32-bit words from the gateway's rx FIFO interface in the `rx_clk` domain. Delineates frames (header, payload, checksum), forwards the payload as a framed valid/ready stream, and reports per-frame checksum status. Words before a valid sync header are discarded and counted.

---
 rtl/rx_frame_parser_pkg.sv | 26 ++
 rtl/rx_frame_parser_skid_buffer.sv | 61 ++++++
 rtl/rx_frame_parser.sv | 104 ++++++++++
 3 files changed

// File: rtl/rx_frame_parser_pkg.sv
// Shared definitions for the rx frame parser: states, sync default
// and header field helpers.
package rx_frame_parser_pkg;

  localparam logic [15:0] SYNC_DEFAULT = 16'hA55A;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  // Header layout: {sync[31:16], opcode[15:8], len[7:0]}
  function automatic logic [15:0] hdr_sync(input logic [31:0] w);
    return w[31:16];
  endfunction

  function automatic logic [7:0] hdr_op(input logic [31:0] w);
    return w[15:8];
  endfunction

  function automatic logic [7:0] hdr_len(input logic [31:0] w);
    return w[7:0];
  endfunction

endpackage

// File: rtl/rx_frame_parser_skid_buffer.sv
// 2-entry register FIFO fed by the gateway rx FIFO.
// Ports: push/din write, pop/head read, count, rd_en to the FIFO.
module rx_skid_buffer #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din,
  output logic        rd_en,
  output logic [31:0] head,
  output logic [1:0]  count
);

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic        inflight;
  logic        live;
  logic        wr;
  logic        rd;

  // Only words we actually requested are accepted.
  assign wr = push && inflight;
  assign rd = pop && (count != 2'd0);
  assign head = mem[rd_ptr];

  // A request is counted as occupancy until its data returns,
  // so the buffer can never overflow.
  assign rd_en = live &&
    ((count + {1'b0, inflight}) < 2'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      inflight <= 1'b0;
      live     <= 1'b0;
      count    <= 2'd0;
    end else begin
      live     <= 1'b1;
      inflight <= rd_en;
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({wr, rd})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_frame_parser.sv
// Frame delineator: hunts sync headers, forwards payload cut-through,
// checks the trailing sum word and counts discarded words.
module rx_frame_parser
  import rx_frame_parser_pkg::*;
#(
  parameter logic [15:0] SYNC      = SYNC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        rx_clk,
  input  logic        rst,
  output logic        rx_ready,
  input  logic        rx_valid,
  input  logic [31:0] rx_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_first,
  output logic        m_last,
  output logic [7:0]  m_opcode,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] drop_cnt
);

  state_t      state;
  logic [31:0] head;
  logic [1:0]  count;
  logic        empty;
  logic        pop;
  logic [7:0]  opcode;
  logic [7:0]  remaining;
  logic [31:0] sum;
  logic        first;

  assign empty = (count == 2'd0);
  assign pop = !empty && ((state != PAYLOAD) || m_ready);

  rx_skid_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (rx_clk),
    .rst   (rst),
    .push  (rx_valid),
    .pop   (pop),
    .din   (rx_data),
    .rd_en (rx_ready),
    .head  (head),
    .count (count)
  );

  assign m_valid  = (state == PAYLOAD) && !empty;
  assign m_data   = head;
  assign m_first  = m_valid && first;
  assign m_last   = m_valid && (remaining == 8'd1);
  assign m_opcode = opcode;

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      opcode     <= '0;
      remaining  <= '0;
      sum        <= '0;
      first      <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      frame_done <= 1'b0;
      if (!empty) begin
        unique case (state)
          HUNT: begin
            if (hdr_sync(head) == SYNC) begin
              opcode    <= hdr_op(head);
              remaining <= hdr_len(head);
              sum       <= head;
              first     <= 1'b1;
              state     <= (hdr_len(head) != 8'd0) ?
                           PAYLOAD : CHECK;
            end else if (drop_cnt != 16'hFFFF) begin
              drop_cnt <= drop_cnt + 16'd1;
            end
          end
          PAYLOAD: begin
            if (m_ready) begin
              sum       <= sum + head;
              remaining <= remaining - 8'd1;
              first     <= 1'b0;
              if (remaining == 8'd1) begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            frame_done <= 1'b1;
            frame_ok   <= (head == sum);
            state      <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
